ssp_uart_top: RTL and testbench
===============================

Name: ssp_uart_top

Overview:
- Register-mapped UART with an SSP-style slave register port.
- Five 12-bit registers: control, status, transmit data, receive data, baud divisor.
- 8-deep transmit and receive FIFOs; serialises 8N1 frames on an RS-232 or RS-485 pin pair.
- Sits between the host SSP bus and external line drivers.

Parameters:
- FIFO_DEPTH, 8, entries per FIFO (power of two).
- DATA_W, 12, register/bus width.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous reset, active-low.
- SSP_SCK  in  1  SSP serial clock; unused, present for interface compatibility.
- SSP_SSEL  in  1  slave select, active-high.
- SSP_RA  in  3  register address.
- SSP_WnR  in  1  1=write, 0=read.
- SSP_En  in  1  access enable.
- SSP_EOC  in  1  end-of-cycle strobe, one Clk wide; commits the access.
- SSP_DI  in  12  write data.
- SSP_DO  out  12  read data.
- RxD_232  in  1  RS-232 receive.
- xCTS  in  1  clear-to-send, active-low.
- RxD_485  in  1  RS-485 receive.
- TxD_232  out  1  RS-232 transmit.
- xRTS  out  1  request-to-send, active-low.
- TxD_485  out  1  RS-485 transmit.
- xDE  out  1  RS-485 driver enable.
- IRQ  out  1  interrupt.

Behaviour:
- Register map (SSP_RA):
  - 0 UCR (R/W).
  - 1 USR (RO).
  - 2 TDR (WO, reads 0).
  - 3 RDR (RO).
  - 4 SPR (R/W).
  - 5–7: read 0, writes ignored.
  - All registers read 12'h000 after reset.
- Access selected when SSP_SSEL & SSP_En.
  - SSP_DO is combinational from the selected register while selected, else 0.
  - Commit on the Clk edge where selected & SSP_EOC.
  - SSP_WnR=1: write SSP_DI. SSP_WnR=0 at RDR: pop rx FIFO.
- UCR bits:
  - [11] TFC: write 1 clears tx FIFO; self-clearing, reads 0.
  - [10] RFC: write 1 clears rx FIFO and USR.ROV; self-clearing, reads 0.
  - [9] MD: 0=RS-232, 1=RS-485.
  - [8] HS: CTS/RTS handshake enable.
  - [7] TIE, [6] RIE.
  - [5:0] reserved, read 0.
- USR bits:
  - [11:8] rx count 0..8; [7:4] tx count 0..8.
  - [3] ROV: sticky rx overrun.
  - [2] TBSY: frame in progress.
  - [1] TFF: tx FIFO full.
  - [0] RDA: rx FIFO not empty.
- TDR write pushes SSP_DI[7:0] into the tx FIFO; dropped if full.
- RDR read:
  - Returns {4'h0, head}; pop takes effect on the EOC edge.
  - Empty FIFO returns 0, no pop.
- SPR: bit period = SPR+1 Clk cycles.
- Transmit:
  - Starts when tx FIFO non-empty, transmitter idle, and (HS=0 or xCTS=0). Pops on start.
  - Frame: start 0, 8 data bits LSB first, stop 1; each bit lasts SPR+1 cycles.
  - Line idle level 1.
  - MD selects the active pin; the other pin holds 1.
  - RS-485: xDE=1 from the start bit through the end of the stop bit, else 0.
  - Back-to-back frames carry no extra idle.
- Receive:
  - Line is RxD_485 if MD else RxD_232, synchronised through 2 flops.
  - Falling edge while idle starts a frame. Start bit re-sampled at half period; if high, abort.
  - Data sampled at mid-bit. Stop sampled mid-bit; stop=0 discards the byte.
  - Valid byte pushed to rx FIFO. If full: byte dropped, ROV set.
- xRTS = HS & rx FIFO full, else 0.
- IRQ = (RIE & RDA) | (TIE & tx count==0 & ~TBSY).
- Simultaneous events:
  - TFC with TDR push: clear wins.
  - RFC with rx push or RDR pop: clear wins.
  - Push+pop on the same FIFO in one cycle: both occur, count unchanged.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- TFC mid-frame: the current frame completes; queued bytes are discarded.
- Reset (Rst=0 at a Clk edge), any time including mid-frame:
  - All registers, FIFOs and state machines cleared.
  - TxD_232=TxD_485=1, xDE=0, xRTS=0, IRQ=0.

Test Plan:
- Register reset: after Rst low 10 cycles then high, read UCR/USR/TDR/RDR/SPR -> all 12'h000.
- Register R/W: write UCR=12'h3C0, SPR=12'hABC -> read back 12'h3C0, 12'hABC. Write 12'hFFF to UCR -> reads 12'h3C0. Address 5 reads 0.
- TX FIFO clear: SPR=100, push 5 bytes -> USR[7:4]=4 after first pop. Write UCR TFC -> tx count 0; TxD_232 finishes current frame, then idles 1.
- RX FIFO clear: SPR=3, loop 3 bytes 8'h55/8'hA5/8'h0F into RxD_232 -> USR[11:8]=3, RDA=1. Set RFC -> count 0, RDR reads 0.
- Loopback/order: SPR=7, push 8'h41, 8'h42, route TxD to RxD -> RDR returns 12'h041 then 12'h042; 9 received into full FIFO -> ROV=1.
- RS-485 + handshake: MD=1, HS=1, xCTS=1, push byte -> no start. xCTS=0 -> xDE=1 for 10 bit periods; TxD_232 held 1.

Source files
------------

// File: rtl/ssp_uart_top.sv
// Register-mapped 8N1 UART behind an SSP-style slave register port.
// Each direction has its own FIFO, and the line side supports RS-232 or RS-485.
module ssp_uart_top #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DATA_W     = 12
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              SSP_SCK,
    input  logic              SSP_SSEL,
    input  logic [2:0]        SSP_RA,
    input  logic              SSP_WnR,
    input  logic              SSP_En,
    input  logic              SSP_EOC,
    input  logic [DATA_W-1:0] SSP_DI,
    output logic [DATA_W-1:0] SSP_DO,
    input  logic              RxD_232,
    input  logic              xCTS,
    input  logic              RxD_485,
    output logic              TxD_232,
    output logic              xRTS,
    output logic              TxD_485,
    output logic              xDE,
    output logic              IRQ
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // The serial clock is not needed: all register accesses are timed by Clk and SSP_EOC.
    logic unused_sck;
    assign unused_sck = SSP_SCK;

    // Register access decode
    logic sel, commit, wr_ucr, wr_tdr, wr_spr, rd_rdr, tfc, rfc;
    assign sel    = SSP_SSEL & SSP_En;
    assign commit = sel & SSP_EOC;
    assign wr_ucr = commit &  SSP_WnR & (SSP_RA == 3'd0);
    assign wr_tdr = commit &  SSP_WnR & (SSP_RA == 3'd2);
    assign wr_spr = commit &  SSP_WnR & (SSP_RA == 3'd4);
    assign rd_rdr = commit & ~SSP_WnR & (SSP_RA == 3'd3);
    assign tfc    = wr_ucr & SSP_DI[11];
    assign rfc    = wr_ucr & SSP_DI[10];

    logic              md, hs, tie, rie;
    logic [DATA_W-1:0] spr;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            md  <= 1'b0;
            hs  <= 1'b0;
            tie <= 1'b0;
            rie <= 1'b0;
            spr <= '0;
        end else begin
            if (wr_ucr) begin
                md  <= SSP_DI[9];
                hs  <= SSP_DI[8];
                tie <= SSP_DI[7];
                rie <= SSP_DI[6];
            end
            if (wr_spr) spr <= SSP_DI;
        end
    end

    // Transmit FIFO
    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr, tx_rd;
    logic [CNT_W-1:0] tx_cnt;
    logic             tx_full, tx_push, tx_pop;
    logic [7:0]       tx_head;

    assign tx_full = (tx_cnt == CNT_W'(FIFO_DEPTH));
    assign tx_push = wr_tdr & ~tx_full;
    assign tx_head = tx_mem[tx_rd];

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else if (tfc) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr] <= SSP_DI[7:0];
                tx_wr         <= tx_wr + PTR_W'(1);
            end
            if (tx_pop) tx_rd <= tx_rd + PTR_W'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CNT_W'(1);
                2'b01:   tx_cnt <= tx_cnt - CNT_W'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // Receive FIFO
    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr, rx_rd;
    logic [CNT_W-1:0] rx_cnt;
    logic             rx_full, rx_empty, rx_push, rx_pop, rx_done, rov;
    logic [7:0]       rx_sh;

    assign rx_full  = (rx_cnt == CNT_W'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);
    assign rx_push  = rx_done & ~rx_full;
    assign rx_pop   = rd_rdr & ~rx_empty;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
            rov    <= 1'b0;
        end else if (rfc) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
            rov    <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr] <= rx_sh;
                rx_wr         <= rx_wr + PTR_W'(1);
            end
            if (rx_done & rx_full) rov <= 1'b1;
            if (rx_pop) rx_rd <= rx_rd + PTR_W'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CNT_W'(1);
                2'b01:   rx_cnt <= rx_cnt - CNT_W'(1);
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // Transmitter: the next frame loads on the last cycle of the stop bit, so there is no idle gap
    logic              tx_busy, tx_end;
    logic [9:0]        tx_shift;
    logic [3:0]        tx_idx;
    logic [DATA_W-1:0] tx_baud;

    assign tx_end = tx_busy & (tx_baud >= spr) & (tx_idx == 4'd9);
    assign tx_pop = (tx_cnt != '0) & (~hs | ~xCTS) & (~tx_busy | tx_end);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            tx_busy  <= 1'b0;
            tx_shift <= '1;
            tx_idx   <= '0;
            tx_baud  <= '0;
        end else if (tx_pop) begin
            tx_busy  <= 1'b1;
            tx_shift <= {1'b1, tx_head, 1'b0};
            tx_idx   <= '0;
            tx_baud  <= '0;
        end else if (tx_busy) begin
            if (tx_baud >= spr) begin
                tx_baud  <= '0;
                tx_shift <= {1'b1, tx_shift[9:1]};
                if (tx_idx == 4'd9) tx_busy <= 1'b0;
                else                tx_idx  <= tx_idx + 4'd1;
            end else begin
                tx_baud <= tx_baud + DATA_W'(1);
            end
        end
    end

    // Receiver: 2-flop synchroniser plus one history flop for falling-edge detection
    rx_state_t         rx_state;
    logic              rx_s1, rx_s2, rx_s3;
    logic [2:0]        rx_idx;
    logic [DATA_W-1:0] rx_baud;

    assign rx_done = (rx_state == RX_STOP) & (rx_baud >= spr) & rx_s2;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_idx   <= '0;
            rx_baud  <= '0;
            rx_sh    <= '0;
        end else begin
            rx_s1 <= md ? RxD_485 : RxD_232;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            case (rx_state)
                RX_IDLE: begin
                    rx_baud <= '0;
                    if (~rx_s2 & rx_s3) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_baud >= (spr >> 1)) begin
                        rx_baud  <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_baud <= rx_baud + DATA_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_baud >= spr) begin
                        rx_baud <= '0;
                        rx_sh   <= {rx_s2, rx_sh[7:1]};
                        rx_idx  <= rx_idx + 3'd1;
                        if (rx_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_baud <= rx_baud + DATA_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_baud >= spr) begin
                        rx_baud  <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_baud <= rx_baud + DATA_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Registered line-side outputs; the inactive pin idles high
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            TxD_232 <= 1'b1;
            TxD_485 <= 1'b1;
            xDE     <= 1'b0;
            xRTS    <= 1'b0;
            IRQ     <= 1'b0;
        end else begin
            TxD_232 <= md ? 1'b1 : tx_shift[0];
            TxD_485 <= md ? tx_shift[0] : 1'b1;
            xDE     <= md & tx_busy;
            xRTS    <= hs & rx_full;
            IRQ     <= (rie & ~rx_empty) | (tie & (tx_cnt == '0) & ~tx_busy);
        end
    end

    logic [11:0] usr, rdr;
    assign usr = {4'(rx_cnt), 4'(tx_cnt), rov, tx_busy, tx_full, ~rx_empty};
    assign rdr = rx_empty ? 12'h000 : {4'h0, rx_mem[rx_rd]};

    always_comb begin
        SSP_DO = '0;
        if (sel) begin
            case (SSP_RA)
                3'd0:    SSP_DO = DATA_W'({2'b00, md, hs, tie, rie, 6'b000000});
                3'd1:    SSP_DO = DATA_W'(usr);
                3'd3:    SSP_DO = DATA_W'(rdr);
                3'd4:    SSP_DO = spr;
                default: SSP_DO = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ssp_uart_top.sv
// Directed bench for ssp_uart_top: register port, both FIFOs, loopback, RS-485 and handshake.
`timescale 1ns/1ps
module tb_ssp_uart_top;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ssel = 1'b0, en = 1'b0, wnr = 1'b0, eoc = 1'b0;
    logic [2:0]  ssp_ra = 3'd0;
    logic [11:0] di = 12'h000;
    logic [11:0] do_w;
    logic        rx_drv = 1'b1, rx485 = 1'b1, xcts = 1'b1, loop_en = 1'b0;
    logic        rxd_232;
    logic        txd_232, txd_485, xrts, xde, irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rxd_232 = loop_en ? txd_232 : rx_drv;

    ssp_uart_top #(.FIFO_DEPTH(8), .DATA_W(12)) dut (
        .Clk(clk), .Rst(rst), .SSP_SCK(1'b0), .SSP_SSEL(ssel), .SSP_RA(ssp_ra),
        .SSP_WnR(wnr), .SSP_En(en), .SSP_EOC(eoc), .SSP_DI(di), .SSP_DO(do_w),
        .RxD_232(rxd_232), .xCTS(xcts), .RxD_485(rx485), .TxD_232(txd_232),
        .xRTS(xrts), .TxD_485(txd_485), .xDE(xde), .IRQ(irq)
    );

    // Independent line monitor: decodes 8N1 frames into {stop, data}
    logic       mon_485 = 1'b0;
    int         mon_spr = 100;
    logic       mon_line;
    logic [8:0] mon_fr;
    logic [8:0] mon_q[$];
    assign mon_line = mon_485 ? txd_485 : txd_232;

    always begin
        @(negedge mon_line);
        repeat ((mon_spr + 1) / 2) @(posedge clk);
        #1;
        if (mon_line == 1'b0) begin
            for (int i = 0; i < 9; i++) begin
                repeat (mon_spr + 1) @(posedge clk);
                #1;
                mon_fr[i] = mon_line;
            end
            mon_q.push_back(mon_fr);
        end
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ssp_write(input logic [2:0] ra, input logic [11:0] d);
        @(posedge clk); #1;
        ssel = 1'b1; en = 1'b1; ssp_ra = ra; wnr = 1'b1; di = d; eoc = 1'b1;
        @(posedge clk); #1;
        ssel = 1'b0; en = 1'b0; wnr = 1'b0; eoc = 1'b0;
    endtask

    task automatic ssp_read(input logic [2:0] ra, output logic [11:0] d);
        @(posedge clk); #1;
        ssel = 1'b1; en = 1'b1; ssp_ra = ra; wnr = 1'b0; eoc = 1'b1;
        #3 d = do_w;
        @(posedge clk); #1;
        ssel = 1'b0; en = 1'b0; eoc = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [2:0] ra, input logic [11:0] exp);
        logic [11:0] d;
        ssp_read(ra, d);
        check(tag, d, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int per);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = fr[i];
            repeat (per) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
        repeat (2 * per) @(posedge clk);
        #1;
    endtask

    task automatic frame_check(input string tag, input logic [11:0] exp);
        logic [11:0] f;
        f = 12'hxxx;
        if (mon_q.size() > 0) f = 12'(mon_q.pop_front());
        check(tag, f, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int guard;
        logic low232;

        // Reset state
        rst = 1'b0;
        wait_cycles(10);
        rst = 1'b1;
        check("rst_txd232", {11'b0, txd_232}, 12'h001);
        check("rst_txd485", {11'b0, txd_485}, 12'h001);
        check("rst_xde", {11'b0, xde}, 12'h000);
        check("rst_irq", {11'b0, irq}, 12'h000);
        read_check("rst_ucr", 3'd0, 12'h000);
        read_check("rst_usr", 3'd1, 12'h000);
        read_check("rst_tdr", 3'd2, 12'h000);
        read_check("rst_rdr", 3'd3, 12'h000);
        read_check("rst_spr", 3'd4, 12'h000);

        // Register read/write
        ssp_write(3'd0, 12'h3C0);
        ssp_write(3'd4, 12'hABC);
        read_check("ucr_rb", 3'd0, 12'h3C0);
        read_check("spr_rb", 3'd4, 12'hABC);
        check("irq_tie_empty", {11'b0, irq}, 12'h001);
        ssp_write(3'd0, 12'hFFF);
        read_check("ucr_fff", 3'd0, 12'h3C0);
        ssp_write(3'd5, 12'h123);
        read_check("addr5", 3'd5, 12'h000);

        // Tx FIFO clear while a frame is on the line
        ssp_write(3'd0, 12'h000);
        mon_485 = 1'b0; mon_spr = 100; mon_q.delete();
        ssp_write(3'd4, 12'd100);
        ssp_write(3'd2, 12'h0C3);
        ssp_write(3'd2, 12'h011);
        ssp_write(3'd2, 12'h022);
        ssp_write(3'd2, 12'h033);
        ssp_write(3'd2, 12'h044);
        read_check("usr_tx4", 3'd1, 12'h044);
        ssp_write(3'd0, 12'h800);
        read_check("usr_tfc", 3'd1, 12'h004);
        wait_cycles(1200);
        check("tfc_frames", 12'(mon_q.size()), 12'd1);
        frame_check("tfc_frame0", 12'h1C3);
        read_check("usr_tfc_idle", 3'd1, 12'h000);
        check("tfc_line_idle", {11'b0, txd_232}, 12'h001);

        // Rx FIFO fill, pop, bad stop, clear
        ssp_write(3'd4, 12'd3);
        send_byte(8'h55, 1'b1, 4);
        send_byte(8'hA5, 1'b1, 4);
        send_byte(8'h0F, 1'b1, 4);
        wait_cycles(10);
        read_check("usr_rx3", 3'd1, 12'h301);
        read_check("rdr_55", 3'd3, 12'h055);
        read_check("usr_rx2", 3'd1, 12'h201);
        send_byte(8'h33, 1'b0, 4);
        wait_cycles(10);
        read_check("usr_badstop", 3'd1, 12'h201);
        ssp_write(3'd0, 12'h040);
        wait_cycles(2);
        check("irq_rie", {11'b0, irq}, 12'h001);
        ssp_write(3'd0, 12'h400);
        read_check("usr_rfc", 3'd1, 12'h000);
        read_check("rdr_rfc", 3'd3, 12'h000);
        check("irq_off", {11'b0, irq}, 12'h000);

        // Loopback ordering, tx full, rx overrun, RTS
        ssp_write(3'd4, 12'd7);
        mon_spr = 7; mon_q.delete();
        loop_en = 1'b1;
        ssp_write(3'd2, 12'h041);
        ssp_write(3'd2, 12'h042);
        wait_cycles(250);
        read_check("rdr_41", 3'd3, 12'h041);
        read_check("rdr_42", 3'd3, 12'h042);
        read_check("rdr_empty", 3'd3, 12'h000);
        frame_check("loop_frame0", 12'h141);
        for (int i = 0; i < 9; i++) ssp_write(3'd2, 12'(8'h60 + i));
        read_check("usr_txfull", 3'd1, 12'h086);
        ssp_write(3'd2, 12'h07F);
        read_check("usr_txdrop", 3'd1, 12'h086);
        wait_cycles(900);
        read_check("usr_rov", 3'd1, 12'h809);
        ssp_write(3'd0, 12'h100);
        wait_cycles(2);
        check("rts_full", {11'b0, xrts}, 12'h001);
        read_check("rdr_60", 3'd3, 12'h060);
        wait_cycles(2);
        check("rts_notfull", {11'b0, xrts}, 12'h000);
        read_check("usr_rx7", 3'd1, 12'h709);
        loop_en = 1'b0;

        // RS-485 with CTS handshake
        xcts = 1'b1;
        ssp_write(3'd0, 12'h700);
        mon_485 = 1'b1; mon_q.delete();
        ssp_write(3'd2, 12'h0A5);
        wait_cycles(50);
        read_check("usr_cts_hold", 3'd1, 12'h010);
        check("xde_hold", {11'b0, xde}, 12'h000);
        check("txd485_hold", {11'b0, txd_485}, 12'h001);
        xcts = 1'b0;
        guard = 0;
        while (!xde && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        n = 0;
        low232 = 1'b0;
        while (xde && n < 200) begin
            if (!txd_232) low232 = 1'b1;
            n++;
            @(posedge clk); #1;
        end
        check("xde_cycles", 12'(n), 12'd80);
        check("txd232_held", {11'b0, low232}, 12'h000);
        wait_cycles(20);
        frame_check("rs485_frame", 12'h1A5);
        read_check("usr_485_done", 3'd1, 12'h000);

        // Reset in the middle of a frame
        ssp_write(3'd0, 12'h000);
        mon_485 = 1'b0;
        ssp_write(3'd2, 12'h000);
        ssp_write(3'd2, 12'h000);
        wait_cycles(20);
        check("mid_start_bit", {11'b0, txd_232}, 12'h000);
        rst = 1'b0;
        wait_cycles(1);
        rst = 1'b1;
        check("mid_rst_txd", {11'b0, txd_232}, 12'h001);
        check("mid_rst_xde", {11'b0, xde}, 12'h000);
        check("mid_rst_irq", {11'b0, irq}, 12'h000);
        read_check("mid_rst_usr", 3'd1, 12'h000);
        read_check("mid_rst_spr", 3'd4, 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
